// File: rtl/crosshair_draw_if.sv
// VGA timing plus pixel colour bundle passed between drawing stages.
// master/out drive the bundle, slave/in receive it.
interface vga_if;
  logic [11:0] hcount;
  logic [11:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out    (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport in     (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/crosshair_draw.sv
// Crosshair overlay: frame-latched centre, edge clipping, click-triggered flash.
// One cycle of latency on every timing signal and on rgb.
module crosshair_draw #(
  parameter int          ARM_LEN      = 8,
  parameter int          HALF_WIDTH   = 2,
  parameter logic [11:0] COLOR        = 12'hF00,
  parameter logic [11:0] FLASH_COLOR  = 12'hFF0,
  parameter int          FLASH_FRAMES = 6,
  parameter bit          OPEN_CENTRE  = 1'b0,
  parameter int          GAP          = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        left,
  output logic        flash_active,
  vga_if.in           in,
  vga_if.out          out
);

  localparam int CW = $clog2(FLASH_FRAMES + 1);

  typedef enum logic {IDLE = 1'b0, FLASH = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           vblnk_q;
  logic           left_q;
  logic [11:0]    cx_q, cy_q;
  logic [11:0]    rgb_d;

  logic           fe, ce;
  logic [12:0]    adx, ady;
  logic           hbar, vbar, hole, hit;

  function automatic logic [12:0] abs13(input logic signed [12:0] v);
    return v[12] ? 13'(-v) : 13'(v);
  endfunction

  assign fe = in.vblnk & ~vblnk_q;
  assign ce = left & ~left_q;

  // Zero-extended signed differences: clips at edges instead of wrapping.
  assign adx  = abs13($signed({1'b0, in.hcount}) - $signed({1'b0, cx_q}));
  assign ady  = abs13($signed({1'b0, in.vcount}) - $signed({1'b0, cy_q}));
  assign hbar = (ady <= 13'(HALF_WIDTH)) && (adx <= 13'(ARM_LEN));
  assign vbar = (adx <= 13'(HALF_WIDTH)) && (ady <= 13'(ARM_LEN));
  assign hole = OPEN_CENTRE && (adx <= 13'(GAP)) && (ady <= 13'(GAP));
  assign hit  = (hbar | vbar) & ~hole;

  assign flash_active = (state_q == FLASH);

  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_q <= 1'b0;
      left_q  <= 1'b0;
      cx_q    <= 12'd0;
      cy_q    <= 12'd0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      vblnk_q <= in.vblnk;
      left_q  <= left;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (fe) begin
        cx_q <= xpos;
        cy_q <= ypos;
      end else begin
        cx_q <= cx_q;
        cy_q <= cy_q;
      end
    end
  end

  // A click outranks a frame event, so retriggering never loses a reload.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (ce) begin
          state_d = FLASH;
          cnt_d   = CW'(FLASH_FRAMES);
        end else begin
          state_d = IDLE;
        end
      end
      FLASH: begin
        if (ce) begin
          cnt_d = CW'(FLASH_FRAMES);
        end else if (fe) begin
          if (cnt_q == CW'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    rgb_d = in.rgb;
    if (hit) begin
      rgb_d = (state_q == FLASH) ? FLASH_COLOR : COLOR;
    end else if (in.hcount == 12'd0) begin
      rgb_d = 12'h000;
    end else begin
      rgb_d = in.rgb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out.hcount <= 12'd0;
      out.vcount <= 12'd0;
      out.hsync  <= 1'b0;
      out.vsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.rgb    <= 12'd0;
    end else begin
      out.hcount <= in.hcount;
      out.vcount <= in.vcount;
      out.hsync  <= in.hsync;
      out.vsync  <= in.vsync;
      out.hblnk  <= in.hblnk;
      out.vblnk  <= in.vblnk;
      out.rgb    <= rgb_d;
    end
  end

endmodule

// File: tb/tb_crosshair_draw.sv
// Randomized bench for crosshair_draw: a solid-plus and an open-centre instance
// share stimulus and are compared every cycle against a frame-level model.
module tb_crosshair_draw;

  localparam int          FF = 3;
  localparam logic [11:0] C  = 12'hF00;
  localparam logic [11:0] FC = 12'hFF0;

  logic        clk = 1'b0;
  logic        rst;
  logic        left;
  logic [11:0] xpos, ypos;
  logic        fa_a, fa_b;

  int checks   = 0;
  int failures = 0;

  // model state
  int m_cx, m_cy, m_frames;
  bit m_vb, m_left;

  vga_if vin ();
  vga_if vout_a ();
  vga_if vout_b ();

  always #5 clk = ~clk;

  crosshair_draw #(.FLASH_FRAMES(FF)) dut_a (
    .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos), .left(left),
    .flash_active(fa_a), .in(vin), .out(vout_a)
  );

  crosshair_draw #(.FLASH_FRAMES(FF), .OPEN_CENTRE(1'b1), .GAP(2)) dut_b (
    .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos), .left(left),
    .flash_active(fa_b), .in(vin), .out(vout_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit hit_f(input int h, input int v, input int cx, input int cy, input bit open);
    int dx, dy;
    bit bar;
    dx  = iabs(h - cx);
    dy  = iabs(v - cy);
    bar = (dy <= 2 && dx <= 8) || (dx <= 2 && dy <= 8);
    return bar && !(open && dx <= 2 && dy <= 2);
  endfunction

  task automatic step();
    logic [63:0] ea, eb;
    logic [11:0] ra, rb;
    bit fe, ce, fl;
    if (rst) begin
      ea = 64'd0; eb = 64'd0;
      m_cx = 0; m_cy = 0; m_frames = 0; m_vb = 1'b0; m_left = 1'b0;
    end else begin
      fe = vin.vblnk && !m_vb;
      ce = left && !m_left;
      fl = (m_frames > 0);
      ra = hit_f(vin.hcount, vin.vcount, m_cx, m_cy, 1'b0) ? (fl ? FC : C)
         : ((vin.hcount == 12'd0) ? 12'h000 : vin.rgb);
      rb = hit_f(vin.hcount, vin.vcount, m_cx, m_cy, 1'b1) ? (fl ? FC : C)
         : ((vin.hcount == 12'd0) ? 12'h000 : vin.rgb);
      if (ce) m_frames = FF;
      else if (fe && m_frames > 0) m_frames--;
      if (fe) begin
        m_cx = xpos; m_cy = ypos;
      end
      m_vb = vin.vblnk; m_left = left;
      ea = {23'd0, vin.hcount, vin.vcount, vin.hsync, vin.vsync, vin.hblnk, vin.vblnk,
            ra, (m_frames > 0)};
      eb = {23'd0, vin.hcount, vin.vcount, vin.hsync, vin.vsync, vin.hblnk, vin.vblnk,
            rb, (m_frames > 0)};
    end
    @(posedge clk);
    #1;
    check("out_a", {23'd0, vout_a.hcount, vout_a.vcount, vout_a.hsync, vout_a.vsync,
                    vout_a.hblnk, vout_a.vblnk, vout_a.rgb, fa_a}, ea);
    check("out_b", {23'd0, vout_b.hcount, vout_b.vcount, vout_b.hsync, vout_b.vsync,
                    vout_b.hblnk, vout_b.vblnk, vout_b.rgb, fa_b}, eb);
  endtask

  task automatic pix(input logic [11:0] h, input logic [11:0] v, input logic [11:0] c);
    vin.hcount = h; vin.vcount = v; vin.rgb = c;
    vin.hsync = 1'($urandom); vin.vsync = 1'($urandom); vin.hblnk = 1'($urandom);
    vin.vblnk = 1'b0;
    step();
  endtask

  task automatic frame();
    for (int i = 0; i < 2; i++) begin
      vin.hcount = 12'($urandom); vin.vcount = 12'($urandom); vin.rgb = 12'($urandom);
      vin.hsync = 1'($urandom); vin.vsync = 1'($urandom); vin.hblnk = 1'($urandom);
      vin.vblnk = 1'b1;
      step();
    end
  endtask

  // Mostly pixels within +-15 of (cx,cy), some anywhere on the 12-bit plane.
  task automatic burst(input int n, input int cx, input int cy);
    logic [11:0] h, v;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        h = 12'($urandom); v = 12'($urandom);
      end else begin
        h = 12'(cx + int'($urandom_range(0, 30)) - 15);
        v = 12'(cy + int'($urandom_range(0, 30)) - 15);
      end
      pix(h, v, 12'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1; left = 1'b0; xpos = 12'd0; ypos = 12'd0;
    vin.vblnk = 1'b0;
    pix(12'd5, 12'd5, 12'hABC);
    pix(12'd7, 12'd1, 12'h123);
    check("rst_flash", {63'd0, fa_a}, 64'd0);
    rst = 1'b0;

    // basic draw at (400,300)
    xpos = 12'd400; ypos = 12'd300;
    frame(); burst(80, 400, 300);
    frame(); burst(200, 400, 300);
    pix(12'd400, 12'd300, 12'h0F0); check("ctr_rgb", {52'd0, vout_a.rgb}, {52'd0, C});
    pix(12'd392, 12'd302, 12'h0F0); check("hbar_corner", {52'd0, vout_a.rgb}, {52'd0, C});
    pix(12'd409, 12'd300, 12'h123); check("beyond_arm", {52'd0, vout_a.rgb}, 64'h123);
    pix(12'd403, 12'd292, 12'h321); check("beside_vbar", {52'd0, vout_a.rgb}, 64'h321);

    // edge clip at (0,0)
    xpos = 12'd0; ypos = 12'd0;
    frame(); burst(200, 0, 0);
    pix(12'd4092, 12'd0, 12'h456); check("no_wrap", {52'd0, vout_a.rgb}, 64'h456);
    pix(12'd0, 12'd10, 12'h789);   check("col0_blank", {52'd0, vout_a.rgb}, 64'h000);
    pix(12'd8, 12'd2, 12'h789);    check("clip_corner", {52'd0, vout_a.rgb}, {52'd0, C});

    // tear-free latch
    xpos = 12'd100; ypos = 12'd50;
    frame(); burst(40, 100, 50);
    xpos = 12'd500;
    burst(60, 100, 50);
    pix(12'd100, 12'd50, 12'h111); check("tear_old", {52'd0, vout_a.rgb}, {52'd0, C});
    pix(12'd500, 12'd50, 12'h222); check("tear_new", {52'd0, vout_a.rgb}, 64'h222);
    frame(); burst(60, 500, 50);
    pix(12'd500, 12'd50, 12'h222); check("next_frame", {52'd0, vout_a.rgb}, {52'd0, C});

    // open centre at (200,200)
    xpos = 12'd200; ypos = 12'd200;
    frame(); burst(100, 200, 200);
    pix(12'd200, 12'd200, 12'h0AB); check("hole_ctr", {52'd0, vout_b.rgb}, 64'h0AB);
    pix(12'd202, 12'd198, 12'h0CD); check("hole_edge", {52'd0, vout_b.rgb}, 64'h0CD);
    pix(12'd203, 12'd200, 12'h0EF); check("arm_x", {52'd0, vout_b.rgb}, {52'd0, C});
    pix(12'd200, 12'd205, 12'h0EF); check("arm_y", {52'd0, vout_b.rgb}, {52'd0, C});

    // flash: one-cycle pulse, then held high for 1000 cycles
    left = 1'b1; pix(12'd1, 12'd1, 12'h000);
    check("flash_rise", {63'd0, fa_a}, 64'd1);
    pix(12'd200, 12'd200, 12'h000);
    check("flash_color", {52'd0, vout_a.rgb}, {52'd0, FC});
    left = 1'b0; pix(12'd1, 12'd1, 12'h000);
    left = 1'b1;
    for (int f = 0; f < 16; f++) begin
      frame(); burst(60, 200, 200);
    end
    check("flash_over", {63'd0, fa_a}, 64'd0);
    pix(12'd200, 12'd200, 12'h000);
    check("color_after", {52'd0, vout_a.rgb}, {52'd0, C});

    // retrigger, then reset mid-flash
    left = 1'b0; pix(12'd3, 12'd3, 12'h000);
    left = 1'b1; pix(12'd3, 12'd3, 12'h000); left = 1'b0;
    frame(); burst(30, 200, 200);
    frame(); burst(30, 200, 200);
    left = 1'b1; pix(12'd3, 12'd3, 12'h000); left = 1'b0;
    frame(); burst(30, 200, 200);
    frame(); burst(30, 200, 200);
    check("retrig_hold", {63'd0, fa_a}, 64'd1);
    rst = 1'b1; pix(12'd200, 12'd200, 12'hFFF);
    check("rst_fa", {63'd0, fa_a}, 64'd0);
    check("rst_rgb", {52'd0, vout_a.rgb}, 64'd0);
    rst = 1'b0;
    burst(100, 0, 0);
    frame(); burst(100, 200, 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
